// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side and SRAM-pin signals of the arbiter.
// master = requesters plus SRAM pin model, slave = the arbiter itself.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 48
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_ce;
    logic              sram_oen;
    logic              sram_wen;
    logic              busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output sram_dq_in,
        input  ack0, ack1, rdata, busy,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce, sram_oen, sram_wen
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  sram_dq_in,
        output ack0, ack1, rdata, busy,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce, sram_oen, sram_wen
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between display reads (port 0, high
// priority) and host traffic (port 1), sequencing strobes with a fixed
// access time and a bus-turnaround cycle.
// Ports: clk, rstn (async active-low), bus (sram_arbiter_if.slave) carrying
// req/we/addr/wdata/ack per port, rdata, SRAM pins and busy.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 48,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_BURST   = 4
) (
    input logic           clk,
    input logic           rstn,
    sram_arbiter_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [BST_W-1:0] BST_MAX  = BST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BST_W-1:0]  burst, burst_d;
    logic              we_q, we_d;
    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              oe_q, oe_d;
    logic              ce_q, ce_d;
    logic              oen_q, oen_d;
    logic              wen_q, wen_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              win0;

    // Port 0 wins unless port 1 has already waited through a full burst.
    assign win0 = bus.req0 && !(bus.req1 && burst == BST_MAX);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        burst_d = burst;
        we_d    = we_q;
        win_d   = win_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;
        ce_d    = ce_q;
        oen_d   = oen_q;
        wen_d   = wen_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    win_d   = !win0;
                    we_d    = win0 ? bus.we0 : bus.we1;
                    addr_d  = win0 ? bus.addr0 : bus.addr1;
                    dout_d  = win0 ? bus.wdata0 : bus.wdata1;
                    ce_d    = 1'b0;
                    oen_d   = we_d;
                    wen_d   = !we_d;
                    oe_d    = we_d;
                    burst_d = (win0 && bus.req1) ? burst + BST_W'(1) : '0;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    if (!we_q) rdata_d = bus.sram_dq_in;
                    ack0_d  = !win_q;
                    ack1_d  = win_q;
                    ce_d    = 1'b1;
                    oen_d   = 1'b1;
                    wen_d   = 1'b1;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                // Write data stays driven one extra cycle past wen rising.
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            burst   <= '0;
            we_q    <= 1'b0;
            win_q   <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
            ce_q    <= 1'b1;
            oen_q   <= 1'b1;
            wen_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            burst   <= burst_d;
            we_q    <= we_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            ce_q    <= ce_d;
            oen_q   <= oen_d;
            wen_q   <= wen_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dout_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_ce     = ce_q;
    assign bus.sram_oen    = oen_q;
    assign bus.sram_wen    = wen_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 48-bit async SRAM between two requesters.
  - Port 0: display scan-out reads, high priority.
  - Port 1: host read/write path, e.g. uart-loaded or CPU traffic.
- Sequences SRAM control strobes with a fixed, parameterised access time and a bus-turnaround cycle.
- Sits between the gpu/host logic and the top-level SRAM pins; the tristate buffer lives at top level and is driven by sram_dq_out/sram_dq_oe.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 48, SRAM data width.
- WAIT_CYCLES, 2, clk cycles strobes are held per access (>=1).
- MAX_BURST, 4, consecutive port-0 grants allowed while port 1 waits.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request; held with its payload until ackN
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_out  out  DATA_W  data to drive on the pins
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pins
- sram_dq_in  in  DATA_W  sampled pin data
- sram_ce / sram_oen / sram_wen  out  1  active-low SRAM strobes
- busy  out  1  high when not in IDLE

Behaviour:
- Reset (rstn low, asynchronous, immediate, including mid-access):
  - sram_ce = sram_oen = sram_wen = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
  - ack0 = ack1 = 0; rdata = 0; busy = 0.
  - state = IDLE; cnt = 0; burst counter = 0.
  - No ack is issued for an interrupted access.
- States: IDLE -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - At an edge with req0 or req1 high, pick the winner:
    - port 0 if req0 and not (req1 and burst == MAX_BURST);
    - otherwise port 1.
  - Register sram_addr and sram_dq_out from the winner's payload; latch we and the winner id.
  - Set sram_ce = 0. For a read, set sram_oen = 0. For a write, set sram_wen = 0 and sram_dq_oe = 1.
  - Load cnt = WAIT_CYCLES - 1; go to ACCESS.
- Burst counter (updated at grant):
  - port 0 granted while req1 high: burst + 1;
  - port 1 granted, or req1 low: burst = 0.
- ACCESS:
  - Hold all strobes. Decrement cnt each edge.
  - At the edge where cnt == 0:
    - For a read, capture sram_dq_in into rdata.
    - Assert ack of the winner for exactly one cycle.
    - Set sram_ce = sram_oen = sram_wen = 1, keeping sram_dq_oe and sram_dq_out unchanged (write data hold).
    - Go to RECOVER.
- RECOVER: at the next edge set sram_dq_oe = 0, ack = 0; go to IDLE.
  - This is the turnaround cycle; the requester drops or renews req during it.
- Latency: req sampled at edge E in IDLE -> ack high in the cycle after edge E + WAIT_CYCLES.
  - Minimum request-to-request spacing is WAIT_CYCLES + 2 cycles.
- Requests arriving while busy are not lost; they are evaluated at the next IDLE edge.
- Payload changes while busy are ignored, because the payload is latched at grant.
- ack0 and ack1 are never high together; an ack only follows a grant of that port.
- sram_wen and sram_oen are never low together.
- sram_dq_oe is never 1 during a read access.

Test Plan:
- Single read, WAIT_CYCLES = 2: req1 = 1, we1 = 0, addr1 = 0x12345, sram_dq_in = 0xA5A5_0000_1234 -> sram_ce/sram_oen low 2 cycles, sram_addr = 0x12345, ack1 in the 3rd cycle after sampling, rdata = 0xA5A5_0000_1234, sram_dq_oe stays 0.
- Single write: req0 = 1, we0 = 1, addr0 = 0x00010, wdata0 = 0xDEAD_BEEF_CAFE -> sram_wen low 2 cycles, sram_dq_oe high 3 cycles, sram_dq_out = 0xDEAD_BEEF_CAFE, ack0 one cycle, sram_oen stays 1.
- Simultaneous req0 and req1 from idle -> port 0 granted first; port 1 acked in the following access; ack pulses never overlap.
- Starvation guard: req0 and req1 held continuously, MAX_BURST = 4 -> grant order 0,0,0,0,1,0,0,0,0,1 (checked by the ack sequence).
- Reset mid-access: assert rstn = 0 during the second ACCESS cycle of a write -> sram_wen, sram_ce = 1 and sram_dq_oe = 0 immediately, no ack; after release, busy = 0 and a new req1 read completes normally.
- Back-to-back reads by port 1 holding req1 with a new addr1 after each ack -> ack spacing exactly WAIT_CYCLES + 2 = 4 cycles, rdata tracks sram_dq_in per address.
